// File: rtl/sid_spi_regs_multi.sv
// SPI mode-0 register bank for NUM_VOICES SID voices. It decodes 16-bit frames into
// per-voice parameter bytes, supports readback on MISO and pulses a strobe on each committed write.
module sid_spi_regs_multi #(
    parameter int NUM_VOICES  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_clk,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic [16*NUM_VOICES-1:0] sid_frequency,
    output logic [8*NUM_VOICES-1:0]  sid_duration,
    output logic [8*NUM_VOICES-1:0]  sid_attack,
    output logic [8*NUM_VOICES-1:0]  sid_sustain,
    output logic [8*NUM_VOICES-1:0]  sid_waveform,
    output logic                     wr_strobe,
    output logic [3:0]               wr_voice,
    output logic [2:0]               wr_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic        sclk_prev_q, cs_prev_q;
    logic        sclk_s, cs_s, mosi_s;
    logic        sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
    logic        bit_rise_s, bit_fall_s;
    logic [4:0]  bit_cnt_q;
    logic [15:0] shift_q, frame_q, frame_next_s;
    logic [7:0]  miso_sh_q, rd_byte_s;
    logic        commit_q, miso_q, wr_strobe_q;
    logic [3:0]  wr_voice_q;
    logic [2:0]  wr_addr_q;

    logic [7:0] freq_lo_q  [NUM_VOICES];
    logic [7:0] freq_hi_q  [NUM_VOICES];
    logic [7:0] duration_q [NUM_VOICES];
    logic [7:0] attack_q   [NUM_VOICES];
    logic [7:0] sustain_q  [NUM_VOICES];
    logic [7:0] waveform_q [NUM_VOICES];

    // Input synchronisers plus one extra sample of sclk/cs_n for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s         = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s  = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s  = ~sclk_s & sclk_prev_q;
    assign cs_rise_s    = cs_s & ~cs_prev_q;
    assign cs_fall_s    = ~cs_s & cs_prev_q;
    // Counting is gated by state, not by the current cs_n sample, so a 16th rise that
    // lands together with the cs_n rise is still taken.
    assign bit_rise_s   = sclk_rise_s & ((state_q == ST_HDR) | (state_q == ST_DATA));
    assign bit_fall_s   = sclk_fall_s & (state_q == ST_DATA);
    assign frame_next_s = {shift_q[14:0], mosi_s};

    // Frame state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame next-state logic
    always_comb begin
        state_d = state_q;
        if (cs_rise_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = cs_fall_s ? ST_HDR : ST_IDLE;
                ST_HDR:  state_d = (bit_rise_s && bit_cnt_q == 5'd7)  ? ST_DATA : ST_HDR;
                ST_DATA: state_d = (bit_rise_s && bit_cnt_q == 5'd15) ? ST_DONE : ST_DATA;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Readback byte selected by the header that is completing on this rise
    always_comb begin
        rd_byte_s = 8'h00;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (frame_next_s[6:3] == 4'(v)) begin
                case (frame_next_s[2:0])
                    3'd0:    rd_byte_s = freq_lo_q[v];
                    3'd1:    rd_byte_s = freq_hi_q[v];
                    3'd2:    rd_byte_s = duration_q[v];
                    3'd3:    rd_byte_s = attack_q[v];
                    3'd4:    rd_byte_s = sustain_q[v];
                    3'd5:    rd_byte_s = waveform_q[v];
                    default: rd_byte_s = 8'h00;
                endcase
            end else begin
                rd_byte_s = rd_byte_s;
            end
        end
    end

    // Shift/count datapath, MISO shifter and commit capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q <= 5'd0;
            shift_q   <= 16'h0000;
            frame_q   <= 16'h0000;
            miso_sh_q <= 8'h00;
            miso_q    <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            commit_q <= bit_rise_s && (bit_cnt_q == 5'd15);
            if (bit_rise_s && bit_cnt_q == 5'd15) begin
                frame_q <= frame_next_s;
            end
            if (cs_rise_s || state_q == ST_IDLE) begin
                bit_cnt_q <= 5'd0;
                shift_q   <= 16'h0000;
                miso_sh_q <= 8'h00;
            end else if (bit_rise_s) begin
                shift_q   <= frame_next_s;
                bit_cnt_q <= bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd7) begin
                    miso_sh_q <= frame_next_s[7] ? rd_byte_s : 8'h00;
                end
            end else if (bit_fall_s) begin
                miso_sh_q <= {miso_sh_q[6:0], 1'b0};
            end
            if (cs_rise_s || state_q != ST_DATA) begin
                miso_q <= 1'b0;
            end else if (bit_fall_s) begin
                miso_q <= miso_sh_q[7];
            end
        end
    end

    // Register file write and commit strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_lo_q[v]  <= 8'h00;
                freq_hi_q[v]  <= 8'h00;
                duration_q[v] <= 8'h00;
                attack_q[v]   <= 8'h00;
                sustain_q[v]  <= 8'h00;
                waveform_q[v] <= 8'h00;
            end
            wr_strobe_q <= 1'b0;
            wr_voice_q  <= 4'd0;
            wr_addr_q   <= 3'd0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (commit_q && !frame_q[15] && frame_q[10:8] <= 3'd5) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (frame_q[14:11] == 4'(v)) begin
                        wr_strobe_q <= 1'b1;
                        wr_voice_q  <= frame_q[14:11];
                        wr_addr_q   <= frame_q[10:8];
                        case (frame_q[10:8])
                            3'd0:    freq_lo_q[v]  <= frame_q[7:0];
                            3'd1:    freq_hi_q[v]  <= frame_q[7:0];
                            3'd2:    duration_q[v] <= frame_q[7:0];
                            3'd3:    attack_q[v]   <= frame_q[7:0];
                            3'd4:    sustain_q[v]  <= frame_q[7:0];
                            3'd5:    waveform_q[v] <= frame_q[7:0];
                            default: freq_lo_q[v]  <= freq_lo_q[v];
                        endcase
                    end
                end
            end
        end
    end

    // Output mapping from registered state
    always_comb begin
        spi_miso      = miso_q;
        wr_strobe     = wr_strobe_q;
        wr_voice      = wr_voice_q;
        wr_addr       = wr_addr_q;
        sid_frequency = '0;
        sid_duration  = '0;
        sid_attack    = '0;
        sid_sustain   = '0;
        sid_waveform  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            sid_frequency[16*v +: 16] = {freq_hi_q[v], freq_lo_q[v]};
            sid_duration[8*v +: 8]    = duration_q[v];
            sid_attack[8*v +: 8]      = attack_q[v];
            sid_sustain[8*v +: 8]     = sustain_q[v];
            sid_waveform[8*v +: 8]    = waveform_q[v];
        end
    end

endmodule

// File: tb/tb_sid_spi_regs_multi.sv
// Directed and randomized SPI frames against a register-map model of the SID register bank.
module tb_sid_spi_regs_multi;

    localparam int NV   = 3;
    localparam int HALF = 8;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic spi_clk  = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic [16*NV-1:0] sid_frequency;
    logic [8*NV-1:0]  sid_duration, sid_attack, sid_sustain, sid_waveform;
    logic       wr_strobe;
    logic [3:0] wr_voice;
    logic [2:0] wr_addr;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_reg [NV][6];
    logic [6:0] strobe_q[$];
    logic [6:0] exp_commit_q[$];
    logic [3:0] last_v;
    logic [2:0] last_a;

    always #5 clk = ~clk;

    sid_spi_regs_multi #(.NUM_VOICES(NV), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .sid_frequency(sid_frequency),
        .sid_duration(sid_duration), .sid_attack(sid_attack), .sid_sustain(sid_sustain),
        .sid_waveform(sid_waveform), .wr_strobe(wr_strobe), .wr_voice(wr_voice),
        .wr_addr(wr_addr)
    );

    // Every clock cycle with the strobe high is recorded, so a stretched pulse shows up as extra entries
    always @(negedge clk) begin
        if (wr_strobe) strobe_q.push_back({wr_voice, wr_addr});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_byte(input int v, input int a);
        case (a)
            0:       return sid_frequency[16*v +: 8];
            1:       return sid_frequency[16*v+8 +: 8];
            2:       return sid_duration[8*v +: 8];
            3:       return sid_attack[8*v +: 8];
            4:       return sid_sustain[8*v +: 8];
            5:       return sid_waveform[8*v +: 8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_bank(input string tag);
        for (int v = 0; v < NV; v++)
            for (int a = 0; a < 6; a++)
                check($sformatf("%s_v%0d_a%0d", tag, v, a), {24'h0, dut_byte(v, a)}, {24'h0, exp_reg[v][a]});
    endtask

    task automatic model_clear();
        for (int v = 0; v < NV; v++)
            for (int a = 0; a < 6; a++)
                exp_reg[v][a] = 8'h00;
        last_v = 4'd0;
        last_a = 3'd0;
    endtask

    // A write lands only for rw=0, an existing voice and a mapped address
    task automatic model_write(input logic [15:0] w);
        int vi, ai;
        vi = int'(w[14:11]);
        ai = int'(w[10:8]);
        if (!w[15] && vi < NV && ai <= 5) begin
            exp_reg[vi][ai] = w[7:0];
            exp_commit_q.push_back(w[14:8]);
            last_v = w[14:11];
            last_a = w[10:8];
        end
    endtask

    // MISO seen by the master: zero during the header, read byte MSB first during data, all zero for writes
    function automatic logic [15:0] model_miso(input logic [15:0] w);
        int vi, ai;
        vi = int'(w[14:11]);
        ai = int'(w[10:8]);
        if (!w[15]) return 16'h0000;
        if (vi < NV && ai <= 5) return {8'h00, exp_reg[vi][ai]};
        return 16'h0000;
    endfunction

    // mode 0: normal end, 1: leave cs_n low, 2: raise cs_n together with the last SCLK rise
    task automatic spi_xfer(input logic [15:0] w, input int nbits, input int mode, output logic [15:0] mo);
        mo = 16'h0000;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = w[15-i];
            repeat (HALF) @(negedge clk);
            mo[15-i] = spi_miso;
            spi_clk = 1'b1;
            if (mode == 2 && i == nbits - 1) spi_cs_n = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
        end
        if (mode == 0) begin
            repeat (HALF) @(negedge clk);
            spi_cs_n = 1'b1;
        end
        if (mode != 1) repeat (4*HALF) @(negedge clk);
    endtask

    task automatic check_strobes(input string tag);
        check({tag, "_nstrobe"}, strobe_q.size(), exp_commit_q.size());
        while (strobe_q.size() > 0 && exp_commit_q.size() > 0)
            check({tag, "_strobe_va"}, {25'h0, strobe_q.pop_front()}, {25'h0, exp_commit_q.pop_front()});
        strobe_q.delete();
        exp_commit_q.delete();
        check({tag, "_wr_voice"}, {28'h0, wr_voice}, {28'h0, last_v});
        check({tag, "_wr_addr"}, {29'h0, wr_addr}, {29'h0, last_a});
    endtask

    task automatic run_frame(input logic [15:0] w, input int mode, input string tag);
        logic [15:0] mo, exp_mo;
        exp_mo = model_miso(w);
        model_write(w);
        spi_xfer(w, 16, mode, mo);
        check({tag, "_miso"}, {16'h0, mo}, {16'h0, exp_mo});
        check({tag, "_miso_idle"}, {31'h0, spi_miso}, 32'h0);
        check_strobes(tag);
        check_bank(tag);
    endtask

    initial begin
        logic [15:0] mo, w;
        model_clear();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("reset_miso", {31'h0, spi_miso}, 32'h0);
        check_strobes("reset");
        check_bank("reset");

        run_frame(16'h0812, 0, "w_flo");
        run_frame(16'h0934, 0, "w_fhi");
        check("freq_v1", {16'h0, sid_frequency[31:16]}, 32'h0000_3412);

        run_frame(16'h1541, 0, "w_wave");
        run_frame(16'h9500, 0, "r_wave");

        run_frame(16'h2877, 0, "w_badvoice");
        run_frame(16'h0699, 0, "w_addr6");
        run_frame(16'hA800, 0, "r_badvoice");
        run_frame(16'h8600, 0, "r_addr6");

        spi_xfer(16'h0355, 12, 0, mo);
        check_strobes("abort");
        check_bank("abort");
        run_frame(16'h0355, 0, "w_attack");

        spi_xfer(16'h0A5A, 10, 1, mo);
        rst_n = 1'b0;
        spi_cs_n = 1'b1;
        spi_clk = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        strobe_q.delete();
        exp_commit_q.delete();
        repeat (10) @(negedge clk);
        check_strobes("rst_mid");
        check_bank("rst_mid");
        run_frame(16'h0480, 0, "w_sustain");

        run_frame(16'h1023, 2, "w_simul");

        for (int n = 0; n < 24; n++) begin
            w = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
            run_frame(w, 0, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
